// File: rtl/btpipe_out_source.sv
// Block-throttled pipe-out source: buffers user words in a circular FIFO, streams one block per blockstrobe.
// Latency: ep_datain is registered and shows the popped word one cycle after ep_read.
// Backpressure: wr_full refuses writes unless a pop frees a slot in the same cycle; ep_ready throttles the host by block.
module btpipe_out_source #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                  okClk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_full,
  input  logic                  ep_read,
  input  logic                  ep_blockstrobe,
  output logic                  ep_ready,
  output logic [DATA_W-1:0]     ep_datain,
  output logic [DEPTH_LOG2:0]   fill_count,
  input  logic                  clr_flags,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  proto_err
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(2 ** DEPTH_LOG2);
  localparam logic [CW-1:0] BLOCK_CNT = CW'(BLOCK_WORDS);

  typedef enum logic {IDLE, BURST} state_t;

  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         fill_q, fill_d, words_left_q, words_left_d;
  logic [DATA_W-1:0]     dat_q, dat_d;
  logic                  wr_full_q, wr_full_d, ep_ready_q, ep_ready_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d, perr_q, perr_d;
  logic                  do_wr, do_pop, perr_set;
  state_t                state_q, state_d;

  // Storage array; a write slot freed by a same-cycle pop is read before it is overwritten.
  always_ff @(posedge okClk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  // FIFO pointers, exact fill count, output word and data-path sticky flags.
  always_comb begin
    do_pop   = ep_read && (fill_q != '0);
    do_wr    = wr_en && (!wr_full_q || do_pop);
    wr_ptr_d = do_wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d   = fill_q;
    if (do_wr && !do_pop)      fill_d = fill_q + CW'(1);
    else if (do_pop && !do_wr) fill_d = fill_q - CW'(1);
    wr_full_d = (fill_d == DEPTH_CNT);
    dat_d = dat_q;
    if (do_pop)       dat_d = mem[rd_ptr_q];
    else if (ep_read) dat_d = '0;
    ovf_d = (wr_en && !do_wr)   ? 1'b1 : (clr_flags ? 1'b0 : ovf_q);
    udf_d = (ep_read && !do_pop) ? 1'b1 : (clr_flags ? 1'b0 : udf_q);
  end

  // State register plus all other flops; reset also empties the FIFO and drops any partial block.
  always_ff @(posedge okClk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      dat_q        <= '0;
      wr_full_q    <= 1'b0;
      ep_ready_q   <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      dat_q        <= dat_d;
      wr_full_q    <= wr_full_d;
      ep_ready_q   <= ep_ready_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      perr_q       <= perr_d;
    end
  end

  // Next state: a strobe arms a block, each read consumes one word of it, a strobe mid-block is ignored.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    case (state_q)
      IDLE: begin
        if (ep_blockstrobe) begin
          if (ep_read) begin
            words_left_d = BLOCK_CNT - CW'(1);
            state_d      = (BLOCK_CNT == CW'(1)) ? IDLE : BURST;
          end else begin
            words_left_d = BLOCK_CNT;
            state_d      = BURST;
          end
        end
      end
      BURST: begin
        if (ep_read) begin
          words_left_d = words_left_q - CW'(1);
          if (words_left_q == CW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ep_ready looks ahead to the next state and fill; protocol errors are sticky.
  always_comb begin
    perr_set   = ((state_q == IDLE) && ep_read && !ep_blockstrobe) ||
                 ((state_q == BURST) && ep_blockstrobe);
    perr_d     = perr_set ? 1'b1 : (clr_flags ? 1'b0 : perr_q);
    ep_ready_d = (state_d == IDLE) && (fill_d >= BLOCK_CNT);
  end

  assign wr_full    = wr_full_q;
  assign ep_ready   = ep_ready_q;
  assign ep_datain  = dat_q;
  assign fill_count = fill_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_btpipe_out_source.sv
module tb_btpipe_out_source;

  logic        okClk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_full;
  logic        ep_read = 1'b0;
  logic        ep_blockstrobe = 1'b0;
  logic        ep_ready;
  logic [31:0] ep_datain;
  logic [10:0] fill_count;
  logic        clr_flags = 1'b0;
  logic        overflow, underflow, proto_err;

  int passed = 0;
  int total  = 0;

  btpipe_out_source #(.DATA_W(32), .DEPTH_LOG2(10), .BLOCK_WORDS(256)) dut (
    .okClk(okClk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .ep_read(ep_read), .ep_blockstrobe(ep_blockstrobe), .ep_ready(ep_ready),
    .ep_datain(ep_datain), .fill_count(fill_count), .clr_flags(clr_flags),
    .overflow(overflow), .underflow(underflow), .proto_err(proto_err)
  );

  always #5 okClk = ~okClk;

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic write_seq(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = 32'(base + i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic strobe();
    ep_blockstrobe = 1'b1;
    tick();
    ep_blockstrobe = 1'b0;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; ep_read = 1'b0; ep_blockstrobe = 1'b0; clr_flags = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({ep_ready, wr_full, overflow, underflow, proto_err} !== 5'b0 || fill_count !== 11'd0 || ep_datain !== 32'd0)
      $display("FAIL reset_state: ready=%b full=%b flags=%b%b%b fill=%0d dat=%h required all zero",
               ep_ready, wr_full, overflow, underflow, proto_err, fill_count, ep_datain);
    else passed++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fill_ready();
    write_seq(0, 255);
    total++;
    if (ep_ready !== 1'b0 || fill_count !== 11'd255)
      $display("FAIL ready_at_255: ready=%b fill=%0d required ready=0 fill=255", ep_ready, fill_count);
    else passed++;
    write_seq(255, 1);
    total++;
    if (ep_ready !== 1'b1 || fill_count !== 11'd256)
      $display("FAIL ready_at_256: ready=%b fill=%0d required ready=1 fill=256", ep_ready, fill_count);
    else passed++;
  endtask

  task automatic test_block();
    strobe();
    total++;
    if (ep_ready !== 1'b0) $display("FAIL ready_after_strobe: got %b required 0", ep_ready);
    else passed++;
    for (int i = 0; i < 256; i++) begin
      ep_read = 1'b1;
      tick();
      total++;
      if (ep_datain !== 32'(i) || ep_ready !== 1'b0)
        $display("FAIL block_word_%0d: dat=%0d ready=%b required dat=%0d ready=0", i, ep_datain, ep_ready, i);
      else passed++;
    end
    ep_read = 1'b0;
    total++;
    if (fill_count !== 11'd0 || {overflow, underflow, proto_err} !== 3'b0)
      $display("FAIL block_end: fill=%0d flags=%b%b%b required fill=0 flags=000",
               fill_count, overflow, underflow, proto_err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    write_seq(0, 512);
    strobe();
    for (int i = 0; i < 256; i++) begin
      ep_read = 1'b1;
      tick();
      total++;
      if (ep_datain !== 32'(i))
        $display("FAIL b2b_first_%0d: dat=%0d required %0d", i, ep_datain, i);
      else passed++;
    end
    total++;
    if (ep_ready !== 1'b1 || fill_count !== 11'd256)
      $display("FAIL b2b_reready: ready=%b fill=%0d required ready=1 fill=256", ep_ready, fill_count);
    else passed++;
    // second block opens with strobe and first read in the same cycle
    ep_blockstrobe = 1'b1;
    tick();
    ep_blockstrobe = 1'b0;
    total++;
    if (ep_datain !== 32'd256 || ep_ready !== 1'b0)
      $display("FAIL b2b_strobe_read: dat=%0d ready=%b required dat=256 ready=0", ep_datain, ep_ready);
    else passed++;
    for (int i = 257; i < 512; i++) begin
      tick();
      total++;
      if (ep_datain !== 32'(i))
        $display("FAIL b2b_second_%0d: dat=%0d required %0d", i, ep_datain, i);
      else passed++;
    end
    ep_read = 1'b0;
    tick();
    total++;
    if (fill_count !== 11'd0 || ep_ready !== 1'b0 || proto_err !== 1'b0 || ep_datain !== 32'd511)
      $display("FAIL b2b_end: fill=%0d ready=%b perr=%b dat=%0d required 0,0,0,511",
               fill_count, ep_ready, proto_err, ep_datain);
    else passed++;
  endtask

  task automatic test_full();
    write_seq(0, 1024);
    total++;
    if (wr_full !== 1'b1 || fill_count !== 11'd1024 || overflow !== 1'b0)
      $display("FAIL full_reached: full=%b fill=%0d ovf=%b required 1,1024,0", wr_full, fill_count, overflow);
    else passed++;
    write_seq(32'hDEAD, 1);
    total++;
    if (wr_full !== 1'b1 || fill_count !== 11'd1024 || overflow !== 1'b1)
      $display("FAIL overflow: full=%b fill=%0d ovf=%b required 1,1024,1", wr_full, fill_count, overflow);
    else passed++;
    strobe();
    wr_en = 1'b1; wr_data = 32'hBEEF; ep_read = 1'b1;
    tick();
    wr_en = 1'b0; ep_read = 1'b0;
    total++;
    if (fill_count !== 11'd1024 || ep_datain !== 32'd0 || wr_full !== 1'b1)
      $display("FAIL full_wr_rd: fill=%0d dat=%h full=%b required 1024,0,1", fill_count, ep_datain, wr_full);
    else passed++;
    do_reset();
  endtask

  task automatic test_underflow();
    write_seq(32'h55, 1);
    ep_read = 1'b1;
    tick();
    total++;
    if (ep_datain !== 32'h55 || proto_err !== 1'b1 || underflow !== 1'b0)
      $display("FAIL idle_read: dat=%h perr=%b udf=%b required 55,1,0", ep_datain, proto_err, underflow);
    else passed++;
    tick();
    ep_read = 1'b0;
    total++;
    if (ep_datain !== 32'd0 || underflow !== 1'b1 || proto_err !== 1'b1)
      $display("FAIL underflow: dat=%h udf=%b perr=%b required 0,1,1", ep_datain, underflow, proto_err);
    else passed++;
    clr_flags = 1'b1; ep_read = 1'b1;
    tick();
    ep_read = 1'b0;
    total++;
    if (underflow !== 1'b1 || proto_err !== 1'b1)
      $display("FAIL set_beats_clear: udf=%b perr=%b required 1,1", underflow, proto_err);
    else passed++;
    tick();
    clr_flags = 1'b0;
    total++;
    if (underflow !== 1'b0 || proto_err !== 1'b0 || overflow !== 1'b0)
      $display("FAIL clear_flags: udf=%b perr=%b ovf=%b required 0,0,0", underflow, proto_err, overflow);
    else passed++;
  endtask

  task automatic test_strobe_mid_block();
    write_seq(2000, 256);
    strobe();
    ep_read = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    ep_read = 1'b0;
    strobe();
    total++;
    if (proto_err !== 1'b1) $display("FAIL mid_strobe_perr: got %b required 1", proto_err);
    else passed++;
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    ep_read = 1'b1;
    for (int i = 0; i < 246; i++) tick();
    total++;
    if (ep_datain !== 32'd2255 || proto_err !== 1'b0)
      $display("FAIL mid_strobe_tail: dat=%0d perr=%b required 2255,0", ep_datain, proto_err);
    else passed++;
    tick();
    ep_read = 1'b0;
    total++;
    if (proto_err !== 1'b1 || underflow !== 1'b1)
      $display("FAIL no_reload: perr=%b udf=%b required 1,1", proto_err, underflow);
    else passed++;
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    write_seq(3000, 256);
    strobe();
    ep_read = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    ep_read = 1'b0;
    total++;
    if (ep_datain !== 32'd3099 || fill_count !== 11'd156)
      $display("FAIL pre_reset: dat=%0d fill=%0d required 3099,156", ep_datain, fill_count);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (fill_count !== 11'd0 || ep_datain !== 32'd0 || ep_ready !== 1'b0 || wr_full !== 1'b0 ||
        {overflow, underflow, proto_err} !== 3'b0)
      $display("FAIL async_reset: fill=%0d dat=%0d ready=%b full=%b required all zero",
               fill_count, ep_datain, ep_ready, wr_full);
    else passed++;
    tick();
    rst = 1'b0;
    write_seq(4000, 256);
    total++;
    if (ep_ready !== 1'b1 || fill_count !== 11'd256)
      $display("FAIL reload_ready: ready=%b fill=%0d required 1,256", ep_ready, fill_count);
    else passed++;
    strobe();
    for (int i = 0; i < 256; i++) begin
      ep_read = 1'b1;
      tick();
      total++;
      if (ep_datain !== 32'(4000 + i))
        $display("FAIL reload_word_%0d: dat=%0d required %0d", i, ep_datain, 4000 + i);
      else passed++;
    end
    ep_read = 1'b0;
    total++;
    if (fill_count !== 11'd0 || proto_err !== 1'b0 || underflow !== 1'b0)
      $display("FAIL reload_end: fill=%0d perr=%b udf=%b required 0,0,0", fill_count, proto_err, underflow);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_ready();
    test_block();
    test_back_to_back();
    test_full();
    test_underflow();
    test_strobe_mid_block();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
